// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest serializer state encoding.
package sha256_pkg;

  localparam int SHA256_DIGEST_WIDTH = 256;
  localparam int SHA256_WORD_WIDTH   = 32;
  localparam int SHA256_DIGEST_WORDS = SHA256_DIGEST_WIDTH / SHA256_WORD_WIDTH;

  typedef enum logic {
    eIdle = 1'b0,
    eSend = 1'b1
  } ser_state_e;

endpackage

// File: rtl/sha256_digest_serializer.sv
// Captures a 256-bit digest from the core and streams it as eight 32-bit beats.
// Optional SHA256_SER_BYTE_SWAP_EN byte-reverses each output word.
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
  parameter int WORD_WIDTH   = SHA256_WORD_WIDTH,
  parameter int LSW_FIRST    = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [DIGEST_WIDTH-1:0] digest_i,
  output logic                    yumi_o,
  output logic                    v_o,
  output logic [WORD_WIDTH-1:0]   data_o,
  input  logic                    yumi_i
);

  // Handshakes (both sides): a transfer happens in a cycle where valid and yumi
  // are both high; valid and data stay stable until that cycle.
  localparam int BEATS = DIGEST_WIDTH / WORD_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  ser_state_e              r_state;
  logic [CW-1:0]           r_cnt;
  logic [DIGEST_WIDTH-1:0] r_buf;

  logic                    w_last_take;
  logic                    w_accept;
  logic [CW-1:0]           w_idx;
  logic [WORD_WIDTH-1:0]   w_word;
  logic [WORD_WIDTH-1:0]   w_out;

  // A new digest is taken only when idle or while the final beat leaves.
  assign w_last_take = (r_state == eSend) && (r_cnt == LAST) && yumi_i;
  assign w_accept    = v_i && en_i && ((r_state == eIdle) || w_last_take);
  assign yumi_o      = w_accept;

  assign w_idx  = (LSW_FIRST != 0) ? r_cnt : (LAST - r_cnt);
  assign w_word = r_buf[int'(w_idx) * WORD_WIDTH +: WORD_WIDTH];

  always_comb begin
    w_out = w_word;
`ifdef SHA256_SER_BYTE_SWAP_EN
    for (int i = 0; i < WORD_WIDTH / 8; i++) begin
      w_out[i*8 +: 8] = w_word[WORD_WIDTH - 8 - i*8 +: 8];
    end
`endif
  end

  assign v_o    = (r_state == eSend);
  assign data_o = (r_state == eSend) ? w_out : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= eIdle;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        eIdle: begin
          if (w_accept) begin
            r_buf   <= digest_i;
            r_cnt   <= '0;
            r_state <= eSend;
          end
        end
        eSend: begin
          if (yumi_i) begin
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (w_accept) begin
                r_buf <= digest_i;
              end else begin
                r_state <= eIdle;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= eIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed bench for sha256_digest_serializer; honours SHA256_SER_BYTE_SWAP_EN.
module tb_sha256_digest_serializer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic         v_i;
  logic [255:0] digest_i;
  logic         yumi_o;
  logic         v_o;
  logic [31:0]  data_o;
  logic         yumi_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  abc_h [8];
  logic [255:0] abc_dig;
  logic [255:0] dead_dig;

  always #5 clk_i = ~clk_i;

  sha256_digest_serializer dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .v_i      (v_i),
    .digest_i (digest_i),
    .yumi_o   (yumi_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i)
  );

  function automatic logic [31:0] exp_word(input logic [255:0] dig, input int b);
    logic [31:0] w;
    w = dig[b*32 +: 32];
`ifdef SHA256_SER_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a digest on an idle serializer and check it is taken that cycle.
  task automatic accept(input logic [255:0] dig);
    @(negedge clk_i);
    v_i = 1'b1; en_i = 1'b1; digest_i = dig; yumi_i = 1'b0;
    #1;
    chk("accept_yumi_o", {31'b0, yumi_o}, 32'd1);
  endtask

  // Drain eight beats; mode 1 stalls with a 1,0,0 pattern. nv/nd is what the
  // core presents meanwhile (queued next digest).
  task automatic drain(input logic [255:0] dig, input int mode,
                       input logic nv, input logic [255:0] nd);
    int b = 0;
    int c = 0;
    while (b < 8 && c < 64) begin
      @(negedge clk_i);
      v_i = nv; en_i = 1'b1; digest_i = nd;
      yumi_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      chk($sformatf("v_o_beat%0d", b), {31'b0, v_o}, 32'd1);
      chk($sformatf("data_beat%0d", b), data_o, exp_word(dig, b));
      chk($sformatf("yumi_o_beat%0d", b), {31'b0, yumi_o},
          {31'b0, (b == 7 && yumi_i) ? nv : 1'b0});
      if (yumi_i) b++;
      c++;
    end
    chk("drain_complete", b, 8);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk_i);
    v_i = 1'b0; yumi_i = 1'b0;
    #1;
    chk({tag, "_v_o"}, {31'b0, v_o}, 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
  endtask

  initial begin
    abc_h[0] = 32'hba7816bf; abc_h[1] = 32'h8f01cfea;
    abc_h[2] = 32'h414140de; abc_h[3] = 32'h5dae2223;
    abc_h[4] = 32'hb00361a3; abc_h[5] = 32'h96177a9c;
    abc_h[6] = 32'hb410ff61; abc_h[7] = 32'hf20015ad;
    for (int i = 0; i < 8; i++) abc_dig[i*32 +: 32] = abc_h[i];
    dead_dig = {8{32'hdeadbeef}};

    // Reset for two cycles
    reset_i = 1'b0; en_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; digest_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_v_o", {31'b0, v_o}, 32'd0);
    chk("reset_data", data_o, 32'd0);
    chk("reset_yumi_o", {31'b0, yumi_o}, 32'd0);
    // Stimulus during reset must not be accepted
    v_i = 1'b1; en_i = 1'b1; digest_i = abc_dig;
    @(negedge clk_i);
    chk("reset_hold_v_o", {31'b0, v_o}, 32'd0);
    v_i = 1'b0;
    reset_i = 1'b1;

    // Test 1 / 6: single digest at full rate
    accept(abc_dig);
    drain(abc_dig, 0, 1'b0, '0);
`ifdef SHA256_SER_BYTE_SWAP_EN
    chk("swap_first_literal", exp_word(abc_dig, 0), 32'hbf1678ba);
    chk("swap_last_literal", exp_word(abc_dig, 7), 32'had1500f2);
`endif
    expect_idle("t1_after");

    // Test 2: consumer stall
    accept(abc_dig);
    drain(abc_dig, 1, 1'b0, '0);
    expect_idle("t2_after");

    // Test 3: back-to-back digests, no bubble
    accept(abc_dig);
    drain(abc_dig, 0, 1'b1, dead_dig);
    drain(dead_dig, 0, 1'b0, '0);
    expect_idle("t3_after");

    // Test 4: reset after three beats, then restart at H0
    accept(abc_dig);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      v_i = 1'b0; yumi_i = 1'b1;
      #1;
      chk($sformatf("t4_pre_beat%0d", b), data_o, exp_word(abc_dig, b));
    end
    @(negedge clk_i);
    yumi_i = 1'b0; reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("t4_reset_v_o", {31'b0, v_o}, 32'd0);
    chk("t4_reset_data", data_o, 32'd0);
    accept(abc_dig);
    drain(abc_dig, 0, 1'b0, '0);
    expect_idle("t4_after");

    // Test 5: enable gating
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      en_i = 1'b0; v_i = 1'b1; digest_i = dead_dig; yumi_i = 1'b1;
      #1;
      chk($sformatf("t5_gate_yumi_o%0d", i), {31'b0, yumi_o}, 32'd0);
      chk($sformatf("t5_gate_v_o%0d", i), {31'b0, v_o}, 32'd0);
    end
    accept(dead_dig);
    drain(dead_dig, 0, 1'b0, '0);
    expect_idle("t5_after");

    // yumi_i while idle is ignored
    @(negedge clk_i);
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    #1;
    chk("idle_yumi_ignored", {31'b0, v_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
